// File: rtl/timer_alarm_pkg.sv
// Shared definitions for the multi-channel alarm scheduler: default sizes,
// the register map and the per-channel control word layout.
package timer_alarm_pkg;

   localparam int DEFAULT_COUNTER_WIDTH = 48;
   localparam int DEFAULT_NUM_CH        = 4;

   // Word addresses on the slot
   localparam logic [4:0] ADDR_CTRL        = 5'd0;
   localparam logic [4:0] ADDR_TIME_LO     = 5'd1;
   localparam logic [4:0] ADDR_TIME_HI     = 5'd2;
   localparam logic [4:0] ADDR_STATUS      = 5'd3;
   localparam logic [4:0] ADDR_IRQ_MASK    = 5'd4;
   localparam logic [4:0] ADDR_CMP_BASE    = 5'd8;   // CMP_LO[i] = 8+2i, CMP_HI[i] = 9+2i
   localparam logic [4:0] ADDR_PER_BASE    = 5'd16;  // PER_LO[i] = 16+2i, PER_HI[i] = 17+2i
   localparam logic [4:0] ADDR_CHCTRL_BASE = 5'd24;  // CH_CTRL[i] = 24+i

   // CH_CTRL layout: bit1 periodic, bit0 arm
   typedef struct packed {
      logic periodic;
      logic arm;
   } ch_cfg_t;

endpackage

// File: rtl/timebase_counter48.sv
// Free-running timebase with enable, clear pulse and the coherent-read
// shadow of the upper word.
module timebase_counter48
   import timer_alarm_pkg::*;
#(
   parameter int WIDTH = DEFAULT_COUNTER_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ctrl_write,  // CTRL register written this cycle
   input  logic [1:0]       ctrl_data,   // {clr, en} from the write data
   input  logic             snap,        // TIME_LO is being read
   output logic             en,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-33:0] shadow
);

   // Enable bit, counter (clear beats increment) and upper-word snapshot.
   // NOTE: every state update here is non-blocking so each register sees
   // the pre-edge values of the others, whatever the statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         en     <= 1'b0;
         count  <= '0;
         shadow <= '0;
      end else begin
         if (ctrl_write) en <= ctrl_data[0];
         if (ctrl_write && ctrl_data[1]) count <= '0;
         else if (en)                    count <= count + WIDTH'(1);
         if (snap) shadow <= count[WIDTH-1:32];
      end
   end

endmodule

// File: rtl/timer_alarm_scheduler.sv
// Alarm scheduler: register file, round-robin scanner sharing one
// comparator/adder across the channels, pending/irq logic and read mux.
module timer_alarm_scheduler
   import timer_alarm_pkg::*;
#(
   parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
   parameter int NUM_CH        = DEFAULT_NUM_CH   // register map holds at most 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              read,
   input  logic              write,
   input  logic [4:0]        reg_addr,
   input  logic [31:0]       wr_data,
   output logic [31:0]       rd_data,
   output logic              irq,
   output logic [NUM_CH-1:0] alarm_pending
);

   localparam int CW = COUNTER_WIDTH;

   logic              wr_en, rd_en;
   logic              en;
   logic [CW-1:0]     count;
   logic [CW-33:0]    shadow;

   logic [CW-1:0]     cmp [NUM_CH];
   logic [CW-1:0]     per [NUM_CH];
   ch_cfg_t           cfg [NUM_CH];
   logic [NUM_CH-1:0] irq_mask;
   logic [NUM_CH-1:0] pending;
   logic [1:0]        ptr;

   logic [CW-1:0]     sel_cmp, sel_per, diff, reload;
   ch_cfg_t           sel_cfg;
   logic              hit, do_reload;
   logic [NUM_CH-1:0] set_vec, clr_vec;

   assign wr_en = cs & write;
   assign rd_en = cs & read;

   timebase_counter48 #(.WIDTH(CW)) u_timebase (
      .clk        (clk),
      .reset      (reset),
      .ctrl_write (wr_en && reg_addr == ADDR_CTRL),
      .ctrl_data  (wr_data[1:0]),
      .snap       (rd_en && reg_addr == ADDR_TIME_LO),
      .en         (en),
      .count      (count),
      .shadow     (shadow)
   );

   // Shared comparator and reload adder for the channel under the pointer.
   // The hit test is the sign of (time - cmp), so it survives timebase wrap.
   always_comb begin
      sel_cmp   = cmp[ptr];
      sel_per   = per[ptr];
      sel_cfg   = cfg[ptr];
      diff      = count - sel_cmp;
      hit       = sel_cfg.arm & ~diff[CW-1];
      reload    = sel_cmp + sel_per;
      do_reload = hit & sel_cfg.periodic & (sel_per != '0);
      set_vec   = hit ? (NUM_CH'(1) << ptr) : '0;
      clr_vec   = (wr_en && reg_addr == ADDR_STATUS) ? wr_data[NUM_CH-1:0] : '0;
   end

   // Scanner pointer, mask, pending (hardware set beats W1C) and channel regs.
   // A software write to CMP or CH_CTRL wins over the hit update of that reg.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr      <= '0;
         irq_mask <= '0;
         pending  <= '0;
         // NOTE: the channel arrays are plain flops and are cleared on reset
         // so that a reset mid-scan cannot leave a stale arm or compare.
         for (int i = 0; i < NUM_CH; i++) begin
            cmp[i] <= '0;
            per[i] <= '0;
            cfg[i] <= '0;
         end
      end else begin
         ptr     <= (ptr == 2'(NUM_CH - 1)) ? 2'd0 : ptr + 2'd1;
         pending <= (pending & ~clr_vec) | set_vec;
         if (wr_en && reg_addr == ADDR_IRQ_MASK) irq_mask <= wr_data[NUM_CH-1:0];
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && (reg_addr == 5'(ADDR_CMP_BASE + 2*i) ||
                          reg_addr == 5'(ADDR_CMP_BASE + 2*i + 1))) begin
               if (reg_addr == 5'(ADDR_CMP_BASE + 2*i)) cmp[i][31:0]    <= wr_data;
               else                                     cmp[i][CW-1:32] <= wr_data[CW-33:0];
            end else if (set_vec[i] && do_reload) begin
               cmp[i] <= reload;
            end
            if (wr_en && reg_addr == 5'(ADDR_PER_BASE + 2*i))     per[i][31:0]    <= wr_data;
            if (wr_en && reg_addr == 5'(ADDR_PER_BASE + 2*i + 1)) per[i][CW-1:32] <= wr_data[CW-33:0];
            if (wr_en && reg_addr == 5'(ADDR_CHCTRL_BASE + i))    cfg[i] <= ch_cfg_t'(wr_data[1:0]);
            else if (set_vec[i] && !do_reload)                    cfg[i].arm <= 1'b0;
         end
      end
   end

   assign alarm_pending = pending;
   assign irq           = |(pending & irq_mask);

   // Combinational read mux; unmapped addresses return 0.
   // NOTE: rd_data gets its default before any branch so no path can infer a latch.
   always_comb begin
      rd_data = '0;
      if (reg_addr == ADDR_CTRL)     rd_data = {31'b0, en};
      if (reg_addr == ADDR_TIME_LO)  rd_data = count[31:0];
      if (reg_addr == ADDR_TIME_HI)  rd_data = 32'(shadow);
      if (reg_addr == ADDR_STATUS)   rd_data = 32'(pending);
      if (reg_addr == ADDR_IRQ_MASK) rd_data = 32'(irq_mask);
      for (int i = 0; i < NUM_CH; i++) begin
         if (reg_addr == 5'(ADDR_CMP_BASE + 2*i))     rd_data = cmp[i][31:0];
         if (reg_addr == 5'(ADDR_CMP_BASE + 2*i + 1)) rd_data = 32'(cmp[i][CW-1:32]);
         if (reg_addr == 5'(ADDR_PER_BASE + 2*i))     rd_data = per[i][31:0];
         if (reg_addr == 5'(ADDR_PER_BASE + 2*i + 1)) rd_data = 32'(per[i][CW-1:32]);
         if (reg_addr == 5'(ADDR_CHCTRL_BASE + i))    rd_data = 32'(cfg[i]);
      end
   end

endmodule

// File: tb/tb_timer_alarm_scheduler.sv
// Self-checking bench for timer_alarm_scheduler: directed scenarios with a
// queue of expected read data consumed as the slot returns it.
module tb_timer_alarm_scheduler;
   import timer_alarm_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs = 1'b0, read = 1'b0, write = 1'b0;
   logic [4:0]  reg_addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic        irq;
   logic [3:0]  alarm_pending;

   timer_alarm_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .cs            (cs),
      .read          (read),
      .write         (write),
      .reg_addr      (reg_addr),
      .wr_data       (wr_data),
      .rd_data       (rd_data),
      .irq           (irq),
      .alarm_pending (alarm_pending)
   );

   always #5 clk = ~clk;

   // Edge counter: time since enable and scanner pointer are derived from it.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int c_en   = 0;   // cyc value just after the edge that started the timebase
   int c_rst  = 0;   // cyc value just after the last reset edge

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] cmp_lo(input int i);
      return ADDR_CMP_BASE + 5'(2*i);
   endfunction
   function automatic logic [4:0] per_lo(input int i);
      return ADDR_PER_BASE + 5'(2*i);
   endfunction
   function automatic logic [4:0] chctrl(input int i);
      return ADDR_CHCTRL_BASE + 5'(i);
   endfunction

   // All tasks start and end 1 time unit after a rising edge.
   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      cs = 1'b1; write = 1'b1; reg_addr = a; wr_data = d;
      @(posedge clk); #1;
      cs = 1'b0; write = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
      exp_t e;
      exp_q.push_back('{tag: tag, exp: exp});
      cs = 1'b1; read = 1'b1; reg_addr = a;
      @(negedge clk);
      e = exp_q.pop_front();
      check(e.tag, rd_data, e.exp);
      @(posedge clk); #1;
      cs = 1'b0; read = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      c_rst = cyc;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Returns cyc at the first falling edge with pending[ch] high, -1 on timeout.
   task automatic wait_pend(input int ch, input int budget, output int seen);
      seen = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (alarm_pending[ch]) begin
            seen = cyc;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   // Position so the next bus cycle is the one in which the scanner visits p.
   task automatic align_ptr(input int p);
      for (int k = 0; k < 8 && ((cyc - c_rst) % 4) != p; k++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic preload_time(input logic [47:0] v);
      @(negedge clk);
      dut.u_timebase.count = v;
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          seen, t;
      int          c_a;
      logic [47:0] base, tv;

      do_reset();

      // Reset state
      check("rst_irq", irq, 0);
      check("rst_pending", alarm_pending, 0);
      bus_read(ADDR_CTRL, 0, "rst_ctrl");
      bus_read(ADDR_TIME_LO, 0, "rst_time_lo");
      bus_read(ADDR_STATUS, 0, "rst_status");

      // One-shot on channel 0 at time 100
      bus_write(cmp_lo(0), 100);
      bus_write(chctrl(0), 1);
      bus_write(ADDR_CTRL, 1);
      c_en = cyc;
      bus_read(ADDR_TIME_LO, 0, "time_first_after_en");
      bus_read(ADDR_TIME_LO, 1, "time_second_after_en");
      wait_pend(0, 200, seen);
      t = seen - c_en;
      check("oneshot_seen_at_101_104", (seen >= 0 && t >= 101 && t <= 104), 1);
      bus_read(chctrl(0), 0, "oneshot_arm_cleared");
      bus_read(ADDR_STATUS, 1, "oneshot_status");
      bus_write(ADDR_STATUS, 1);
      bus_read(ADDR_STATUS, 0, "oneshot_w1c");
      while (cyc - c_en < 1000) begin @(posedge clk); #1; end
      check("oneshot_no_refire_1000", alarm_pending, 0);

      // Periodic on channel 1: 50, 90, 130 with irq through the mask
      bus_write(ADDR_CTRL, 2);
      bus_write(cmp_lo(1), 50);
      bus_write(per_lo(1), 40);
      bus_write(ADDR_IRQ_MASK, 2);
      bus_write(chctrl(1), 3);
      bus_write(ADDR_CTRL, 3);
      c_en = cyc;
      bus_read(ADDR_CTRL, 1, "ctrl_clr_reads_0");
      bus_read(5'd5, 0, "unmapped_5");
      bus_read(5'd30, 0, "unmapped_30");
      wait_pend(1, 100, seen);
      t = seen - c_en;
      check("periodic_fire1_51_54", (seen >= 0 && t >= 51 && t <= 54), 1);
      check("irq_follows_pending", irq, 1);
      bus_read(cmp_lo(1), 90, "periodic_cmp_reload1");
      bus_read(chctrl(1), 3, "periodic_arm_kept");
      bus_write(ADDR_STATUS, 2);
      check("periodic_w1c", alarm_pending[1], 0);
      check("irq_drops", irq, 0);
      wait_pend(1, 100, seen);
      t = seen - c_en;
      check("periodic_fire2_91_94", (seen >= 0 && t >= 91 && t <= 94), 1);
      bus_read(cmp_lo(1), 130, "periodic_cmp_reload2");
      bus_write(ADDR_STATUS, 2);
      wait_pend(1, 100, seen);
      t = seen - c_en;
      check("periodic_fire3_131_134", (seen >= 0 && t >= 131 && t <= 134), 1);

      // Wrap-around on channel 2
      bus_write(ADDR_CTRL, 0);
      bus_write(chctrl(1), 0);
      bus_write(ADDR_STATUS, 32'hF);
      check("all_cleared", alarm_pending, 0);
      preload_time(48'hFFFF_FFFF_FFF6);
      bus_write(cmp_lo(2), 5);
      bus_write(chctrl(2), 1);
      bus_write(ADDR_CTRL, 1);
      c_en = cyc;
      wait_pend(2, 40, seen);
      t = seen - c_en;
      check("wrap_no_fire_before_wrap", (seen >= 0 && t > 10), 1);
      check("wrap_fire_time_5_8", (seen >= 0 && t >= 16 && t <= 19), 1);

      // Arming with a compare already in the past fires on the next visit
      bus_write(cmp_lo(3), 2);
      bus_write(chctrl(3), 1);
      c_a = cyc;
      wait_pend(3, 10, seen);
      check("past_cmp_next_visit", (seen >= 0 && seen - c_a >= 1 && seen - c_a <= 4), 1);
      bus_read(chctrl(3), 0, "past_cmp_disarmed");

      // Collisions on channel 3, which hits on every visit (lagging, period 4)
      bus_write(cmp_lo(3), 0);
      bus_write(per_lo(3), 4);
      bus_write(chctrl(3), 3);
      wait_cycles(8);
      align_ptr(3);
      bus_write(ADDR_STATUS, 8);
      check("w1c_vs_hit_keeps_pending", alarm_pending[3], 1);
      align_ptr(0);
      bus_write(ADDR_STATUS, 8);
      check("w1c_off_visit_clears", alarm_pending[3], 0);
      align_ptr(3);
      bus_write(cmp_lo(3), 32'h1234_0000);
      bus_read(cmp_lo(3), 32'h1234_0000, "cmp_write_beats_reload");
      bus_read(cmp_lo(3) + 5'd1, 0, "cmp_hi_untouched");
      bus_read(chctrl(3), 3, "collision_arm_kept");

      // Coherent TIME_LO/TIME_HI across a carry into bit 32
      bus_write(ADDR_CTRL, 0);
      bus_write(chctrl(3), 0);
      bus_write(ADDR_STATUS, 32'hF);
      base = 48'h0012_FFFF_FFFD;
      preload_time(base);
      bus_write(ADDR_CTRL, 1);
      c_en = cyc;
      tv = base + 48'(cyc - c_en);
      bus_read(ADDR_TIME_LO, tv[31:0], "coherent_lo_pre_carry");
      wait_cycles(10);
      bus_read(ADDR_TIME_HI, 32'h12, "coherent_hi_pre_carry");
      tv = base + 48'(cyc - c_en);
      bus_read(ADDR_TIME_LO, tv[31:0], "coherent_lo_post_carry");
      bus_read(ADDR_TIME_HI, 32'h13, "coherent_hi_post_carry");

      // Reset with every channel armed and periodic
      for (int i = 0; i < 4; i++) begin
         bus_write(cmp_lo(i), 32'(i + 1));
         bus_write(per_lo(i), 4);
         bus_write(chctrl(i), 3);
      end
      bus_write(ADDR_IRQ_MASK, 32'hF);
      wait_cycles(8);
      check("pre_reset_irq", irq, 1);
      check("pre_reset_pending", alarm_pending, 4'hF);
      do_reset();
      check("post_reset_irq", irq, 0);
      check("post_reset_pending", alarm_pending, 0);
      bus_read(ADDR_TIME_HI, 0, "post_reset_time_hi");
      bus_read(ADDR_CTRL, 0, "post_reset_ctrl");
      bus_read(ADDR_TIME_LO, 0, "post_reset_time_lo");
      bus_read(ADDR_STATUS, 0, "post_reset_status");
      bus_read(ADDR_IRQ_MASK, 0, "post_reset_mask");
      for (int i = 0; i < 4; i++) begin
         bus_read(cmp_lo(i), 0, $sformatf("post_reset_cmp_lo%0d", i));
         bus_read(cmp_lo(i) + 5'd1, 0, $sformatf("post_reset_cmp_hi%0d", i));
         bus_read(per_lo(i), 0, $sformatf("post_reset_per_lo%0d", i));
         bus_read(per_lo(i) + 5'd1, 0, $sformatf("post_reset_per_hi%0d", i));
         bus_read(chctrl(i), 0, $sformatf("post_reset_chctrl%0d", i));
      end
      check("post_reset_no_fire", alarm_pending, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_alarm_scheduler.md
# timer_alarm_scheduler

Multi-channel alarm scheduler for the MMIO timer slot: a 48-bit free-running timebase plus four alarm channels that share one 48-bit comparator. The comparator is time-multiplexed by a round-robin scanner. Each channel is one-shot or periodic, and alarms set sticky pending bits that drive a maskable interrupt. The block sits on a standard slot (cs/read/write/reg_addr/wr_data/rd_data) next to the plain timer core.

## Interface
- COUNTER_WIDTH, 48: timebase, compare and period width. Upper words are 16 bits wide.
- NUM_CH, 4: alarm channels. The register map supports at most 4.
- clk  in  1: the single clock. Reset is synchronous and active-high.
- reset  in  1: synchronous, active-high, sampled on the rising edge of clk.
- cs  in  1: slot select.
- read  in  1: read strobe. Qualified by cs.
- write  in  1: write strobe. Qualified by cs.
- reg_addr  in  5: register address.
- wr_data  in  32: write data.
- rd_data  out  32: combinational read data for reg_addr. Unmapped addresses return 0.
- irq  out  1: |(pending & irq_mask). Reset value 0.
- alarm_pending  out  NUM_CH: sticky pending bits. Reset value 0.

## Operation
- Register map (word addresses):
  - 0 CTRL: bit0 en (RW); bit1 clr (write-1 pulse, reads 0).
  - 1 TIME_LO (RO).
  - 2 TIME_HI (RO, from the shadow register).
  - 3 STATUS: pending bits; write 1 to clear.
  - 4 IRQ_MASK (RW).
  - 8+2i CMP_LO[i]; 9+2i CMP_HI[i].
  - 16+2i PER_LO[i]; 17+2i PER_HI[i].
  - 24+i CH_CTRL[i]: bit0 arm, bit1 periodic (RW).
- Timebase:
  - Increments every cycle while en=1 and holds while en=0.
  - clr forces 0 and has priority over the increment.
  - Wraps from 2^48-1 to 0.
- Coherent read: a read (cs&read) of TIME_LO latches time[47:32] into a 16-bit shadow. TIME_HI returns {16'h0, shadow}.
- Scanner:
  - A 2-bit pointer ptr advances 0→1→2→3→0 every cycle.
  - It runs regardless of en.
  - Each cycle it evaluates only channel ptr.
- Hit condition: arm[ptr]=1 and (time − cmp[ptr]) mod 2^48 < 2^47. This is a signed-difference test, so it is correct across timebase wrap.
- On a hit on channel i:
  - pending[i] is set.
  - If periodic=1 and period≠0: cmp[i] ← cmp[i]+per[i] (mod 2^48) and arm stays 1.
  - Otherwise arm[i] is cleared.
- Catch-up: if a periodic reload still lands in the past, the channel fires again on its next visit.
- Simultaneous events:
  - A hardware set of pending has priority over a W1C clear in the same cycle.
  - A software write to CMP[i] or CH_CTRL[i] in the same cycle as a hit on i overrides the hardware update of that register. pending[i] is still set.
- Arming with cmp already in the past fires on the channel's next visit.
- Reset returns every register to 0: time, shadow, cmp, per, ch_ctrl, en, mask, pending and ptr. Reset mid-scan discards any in-flight hit.

## Timing
- Register writes take effect at the clock edge where cs&write is asserted.
- Timebase:
  - Reads of TIME_LO show the value registered at the previous edge.
  - The cycle after the edge that writes en=1, time reads 0, then 1, and so on.
- Alarm latency: pending[i] rises 1 to NUM_CH cycles after time first satisfies the hit condition. The worst case is 4 cycles.
- irq is combinational from the registered pending and mask, so it has no added latency.
- Back-to-back periodic alarms: the minimum effective period is 4 cycles, because each channel is visited once per scan. Period values 1 to 3 still fire once per visit via catch-up.

## Structure
- Package timer_alarm_pkg holds:
  - NUM_CH and COUNTER_WIDTH defaults.
  - Register address localparams: ADDR_CTRL, ADDR_TIME_LO, ADDR_TIME_HI, ADDR_STATUS, ADDR_IRQ_MASK, ADDR_CMP_BASE, ADDR_PER_BASE, ADDR_CHCTRL_BASE.
  - Typedef ch_cfg_t, a packed struct {periodic, arm}.
- Sub-module timebase_counter48: contains en, clr, the count and the TIME_HI shadow latch.
- The top level contains the register file, the scanner, the shared comparator/adder and the read mux.

## Test plan
- One-shot: CMP0=100, CH_CTRL0=arm, CTRL.en=1. Required: pending[0] rises within time 100..103, arm[0] reads 0, and no second fire up to time 1000. Then STATUS write 0x1 clears it.
- Periodic: CMP1=50, PER1=40, arm|periodic. Required: fires near 50, 90 and 130. CMP1 reads 90 after the first fire. With IRQ_MASK=0x2, irq follows pending[1].
- Wrap-around: force time near 2^48−10 via a back-door preload, then set CMP2=5. Required: no fire before the wrap and a fire at time 5..8 after it. A CMP value already in the past fires on the next visit.
- Collision: W1C of pending[3] in the same cycle as a hit on channel 3. Required: pending[3] stays 1. Also write CMP3 in the hit cycle of a periodic fire. Required: CMP3 holds the written value, not the reload.
- Coherent read: read TIME_LO just before a carry into bit 32, then read TIME_HI later. Required: TIME_HI returns the pre-carry upper bits.
- Reset mid-operation: assert reset while all channels are armed and periodic. Required: every register reads 0 and irq=0 on the next cycle.
